acc_drain: RTL

- Readout engine on the far side of the accumulator array: snapshots NUM_ACC accumulator outputs on command and clears the accumulators.
- Streams the snapshot out as 16-bit words over a valid/ready interface to the output buffer writer.
- Two output modes: int16 (one accumulator per word) or int8 (two saturated int8 values packed per word).

---
 rtl/acc_drain.sv | 107 ++++++++++
 1 files changed

// File: rtl/acc_drain.sv
// Accumulator readout engine: snapshots all lanes on drain_start, clears them,
// and streams the snapshot as 16-bit words (int16 or packed int8) over valid/ready.
module acc_drain #(
  parameter int NUM_ACC = 8,
  parameter int CNT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drain_start,
  input  logic                    int8_mode,
  input  logic [NUM_ACC*16-1:0]   acc_in_int16,
  input  logic [NUM_ACC*8-1:0]    acc_in_int8,
  output logic                    acc_clr,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [15:0]             out_data,
  output logic                    out_last,
  output logic                    drain_busy,
  output logic                    drain_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [15:0]      snap16_q [NUM_ACC];
  logic [7:0]       snap8_q  [NUM_ACC];

  logic             capture;
  logic             xfer;
  logic [CNT_W-1:0] last_idx;
  logic [15:0]      word;

  assign capture    = (state_q == S_IDLE) && drain_start;
  assign xfer       = (state_q == S_SEND) && out_rdy;
  assign last_idx   = mode_q ? CNT_W'(NUM_ACC/2 - 1) : CNT_W'(NUM_ACC - 1);

  // Clear coincides with the capture edge, so the snapshot holds pre-clear values.
  assign acc_clr    = capture && !rst;
  assign out_vld    = (state_q == S_SEND);
  assign drain_busy = (state_q == S_SEND);
  assign drain_done = (state_q == S_DONE);
  assign out_last   = (state_q == S_SEND) && (cnt_q == last_idx);
  assign out_data   = (state_q == S_SEND) ? word : '0;

  always_comb begin
    word = '0;
    if (mode_q) begin
      for (int unsigned i = 0; i < NUM_ACC/2; i++) begin
        if (cnt_q == CNT_W'(i)) word = {snap8_q[2*i+1], snap8_q[2*i]};
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ACC; i++) begin
        if (cnt_q == CNT_W'(i)) word = snap16_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (drain_start) begin
          state_d = S_SEND;
          cnt_d   = '0;
          mode_d  = int8_mode;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (cnt_q == last_idx) state_d = S_DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_ACC; i++) begin
        snap16_q[i] <= '0;
        snap8_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      if (capture) begin
        for (int unsigned i = 0; i < NUM_ACC; i++) begin
          snap16_q[i] <= acc_in_int16[16*i +: 16];
          snap8_q[i]  <= acc_in_int8[8*i +: 8];
        end
      end
    end
  end

endmodule
